usb_rx_ctrl: RTL and testbench

Receive-side packet controller for the full-speed USB transceiver. It consumes the recovered bit stream and bit-valid strobe from the DPLL together with a sampled SE0 flag, and sequences packet reception. Sequencing covers SYNC detection, NRZI decoding, bit-unstuffing, byte assembly and EOP detection. Its byte/strobe output feeds the packet layer; its error pulse aborts the current packet there.

---
 rtl/usb_rx_ctrl.sv | 152 +++++++++++++++
 tb/tb_usb_rx_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: full-speed USB receive controller (SYNC, NRZI decode, bit-unstuff, bytes, EOP).
// Define USB_RX_STUFF_ERR_EN to treat a 1 in a stuffed bit position as a packet error.
module usb_rx_ctrl #(
    parameter int SYNC_MIN_ZEROS = 5,
    parameter int IDLE_J_BITS    = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_bit,
    input  logic       rx_pulse,
    input  logic       rx_se0,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_eop,
    output logic       rx_error
);
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP, S_ERROR} state_t;

    localparam int            JW       = $clog2(IDLE_J_BITS + 1);
    localparam logic [2:0]    SYNC_MIN = 3'(SYNC_MIN_ZEROS);
    localparam logic [JW-1:0] J_LAST   = JW'(IDLE_J_BITS - 1);

    state_t        state;
    logic          last_level;
    logic [2:0]    zero_cnt;
    logic [2:0]    ones_cnt;
    logic [2:0]    bit_cnt;
    logic [2:0]    se0_cnt;
    logic [JW-1:0] j_cnt;
    logic [7:0]    shreg;

    logic          decoded;
    logic [7:0]    shreg_next;
    logic          stuff_err;
    logic          go_error;

    assign decoded    = (rx_bit == last_level);
    assign shreg_next = {decoded, shreg[7:1]};

`ifdef USB_RX_STUFF_ERR_EN
    assign stuff_err = (ones_cnt == 3'd6) && decoded;
`else
    assign stuff_err = 1'b0;
`endif

    // Every abort condition is gathered here so the sequencer has one error-entry path.
    always_comb begin
        go_error = 1'b0;
        case (state)
            S_SYNC:  go_error = rx_se0 || (decoded && (zero_cnt < SYNC_MIN));
            S_DATA:  go_error = rx_se0 ? (bit_cnt != 3'd0) : stuff_err;
            S_EOP:   go_error = rx_se0 ? (se0_cnt == 3'd3) : !rx_bit;
            default: go_error = 1'b0;
        endcase
    end

    // NOTE: all state and outputs use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            last_level <= 1'b1;
            zero_cnt   <= '0;
            ones_cnt   <= '0;
            bit_cnt    <= '0;
            se0_cnt    <= '0;
            j_cnt      <= '0;
            shreg      <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_active  <= 1'b0;
            rx_eop     <= 1'b0;
            rx_error   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_eop   <= 1'b0;
            rx_error <= 1'b0;
            if (rx_pulse) begin
                if (!rx_se0) begin
                    last_level <= rx_bit;
                end
                if (go_error) begin
                    state     <= S_ERROR;
                    rx_active <= 1'b0;
                    rx_error  <= 1'b1;
                    j_cnt     <= '0;
                end else begin
                    case (state)
                        S_IDLE: begin
                            if (!rx_se0 && !rx_bit) begin
                                state     <= S_SYNC;
                                zero_cnt  <= 3'd1;
                                rx_active <= 1'b1;
                            end
                        end
                        S_SYNC: begin
                            if (!decoded) begin
                                if (zero_cnt != 3'd7) begin
                                    zero_cnt <= zero_cnt + 3'd1;
                                end
                            end else begin
                                state    <= S_DATA;
                                ones_cnt <= 3'd1;
                                bit_cnt  <= 3'd0;
                            end
                        end
                        S_DATA: begin
                            if (rx_se0) begin
                                state   <= S_EOP;
                                se0_cnt <= 3'd1;
                            end else if (ones_cnt == 3'd6) begin
                                ones_cnt <= 3'd0;
                            end else begin
                                shreg    <= shreg_next;
                                ones_cnt <= decoded ? ones_cnt + 3'd1 : 3'd0;
                                bit_cnt  <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) begin
                                    rx_data  <= shreg_next;
                                    rx_valid <= 1'b1;
                                end
                            end
                        end
                        S_EOP: begin
                            if (rx_se0) begin
                                se0_cnt <= se0_cnt + 3'd1;
                            end else begin
                                state      <= S_IDLE;
                                rx_eop     <= 1'b1;
                                rx_active  <= 1'b0;
                                last_level <= 1'b1;
                            end
                        end
                        S_ERROR: begin
                            if (rx_bit && !rx_se0) begin
                                if (j_cnt == J_LAST) begin
                                    state      <= S_IDLE;
                                    j_cnt      <= '0;
                                    last_level <= 1'b1;
                                end else begin
                                    j_cnt <= j_cnt + 1'b1;
                                end
                            end else begin
                                j_cnt <= '0;
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Scoreboard bench for usb_rx_ctrl: packets are built at protocol level (sync, bytes, stuffing,
// NRZI line coding, EOP variants) and the expected byte/eop/error events are queued for a monitor.
module tb_usb_rx_ctrl;
    localparam int SYNC_MIN_ZEROS = 5;
    localparam int IDLE_J_BITS    = 7;

    typedef enum int {EV_VALID, EV_EOP, EV_ERROR} ev_t;
    typedef struct {
        ev_t        kind;
        logic [7:0] data;
    } exp_t;
    typedef enum int {PK_GOOD, PK_PARTIAL, PK_SHORT_SYNC, PK_LONG_SE0, PK_BAD_EOP} pk_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_bit;
    logic       rx_pulse;
    logic       rx_se0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       rx_eop;
    logic       rx_error;

    exp_t       exp_q[$];
    logic [7:0] pkt_bytes[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic       line;    // current line level, 1 = J
    int         ones;    // consecutive decoded ones, for stuffing

    always #5 clk = ~clk;

    usb_rx_ctrl #(
        .SYNC_MIN_ZEROS(SYNC_MIN_ZEROS),
        .IDLE_J_BITS   (IDLE_J_BITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_bit   (rx_bit),
        .rx_pulse (rx_pulse),
        .rx_se0   (rx_se0),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_active(rx_active),
        .rx_eop   (rx_eop),
        .rx_error (rx_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per observed strobe.
    task automatic take(input ev_t kind, input logic [7:0] data);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected strobe: got event %0d, expected none (t=%0t)", kind, $time);
        end else begin
            e = exp_q.pop_front();
            check("event kind", 32'(kind), 32'(e.kind));
            if (e.kind == EV_VALID && kind == EV_VALID) check("rx_data", 32'(data), 32'(e.data));
            check("rx_active at strobe", 32'(rx_active), 32'(kind == EV_VALID));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) take(EV_VALID, rx_data);
            if (rx_eop)   take(EV_EOP, 8'h00);
            if (rx_error) take(EV_ERROR, 8'h00);
        end
    end

    task automatic push(input ev_t kind, input logic [7:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // One DPLL strobe, then 0..4 idle clocks carrying random junk on the unqualified inputs.
    task automatic pulse(input logic b, input logic se0);
        int gap;
        rx_bit   = b;
        rx_se0   = se0;
        rx_pulse = 1'b1;
        @(posedge clk);
        #1;
        rx_pulse = 1'b0;
        rx_bit   = 1'($urandom);
        rx_se0   = 1'($urandom);
        gap      = $urandom_range(0, 4);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_dec(input logic d);
        if (!d) line = ~line;
        pulse(line, 1'b0);
    endtask

    task automatic send_data_bit(input logic d);
        send_dec(d);
        ones = d ? ones + 1 : 0;
        if (ones == 6) begin
            send_dec(1'b0);
            ones = 0;
        end
    endtask

    task automatic send_sync(input int nzeros);
        send_dec(1'b0);
        check("rx_active in sync", 32'(rx_active), 32'd1);
        repeat (nzeros - 1) send_dec(1'b0);
        send_dec(1'b1);
        ones = 1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        push(EV_VALID, b);
        for (int i = 0; i < 8; i++) send_data_bit(b[i]);
    endtask

    task automatic send_eop(input int nse0);
        repeat (nse0) pulse(1'b0, 1'b1);
        push(EV_EOP, 8'h00);
        pulse(1'b1, 1'b0);
        line = 1'b1;
    endtask

    task automatic recover();
        if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, IDLE_J_BITS - 1)) pulse(1'b1, 1'b0);
            pulse(1'b0, 1'($urandom));
        end
        repeat (IDLE_J_BITS) pulse(1'b1, 1'b0);
        line = 1'b1;
    endtask

    task automatic idle_lead();
        int se0;
        repeat ($urandom_range(0, 3)) begin
            se0 = ($urandom_range(0, 3) == 0) ? 1 : 0;
            pulse(1'(1 - se0), 1'(se0));
        end
    endtask

    task automatic run_packet(input pk_t kind, input int nzeros, input int nextra);
        idle_lead();
        check("rx_active idle", 32'(rx_active), 32'd0);
        if (kind == PK_SHORT_SYNC) push(EV_ERROR, 8'h00);
        send_sync(nzeros);
        if (kind != PK_SHORT_SYNC) begin
            foreach (pkt_bytes[i]) send_byte(pkt_bytes[i]);
            case (kind)
                PK_GOOD: send_eop($urandom_range(1, 3));
                PK_PARTIAL: begin
                    repeat (nextra) send_data_bit(1'($urandom));
                    push(EV_ERROR, 8'h00);
                    pulse(1'b0, 1'b1);
                end
                PK_LONG_SE0: begin
                    push(EV_ERROR, 8'h00);
                    repeat (4) pulse(1'b0, 1'b1);
                end
                PK_BAD_EOP: begin
                    repeat ($urandom_range(1, 3)) pulse(1'b0, 1'b1);
                    push(EV_ERROR, 8'h00);
                    pulse(1'b0, 1'b0);
                end
                default: ;
            endcase
        end
        if (kind != PK_GOOD) recover();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rx_data"},   32'(rx_data),   32'd0);
        check({tag, " rx_valid"},  32'(rx_valid),  32'd0);
        check({tag, " rx_active"}, 32'(rx_active), 32'd0);
        check({tag, " rx_eop"},    32'(rx_eop),    32'd0);
        check({tag, " rx_error"},  32'(rx_error),  32'd0);
    endtask

    initial begin
        pk_t kind;
        int  nb;
        rst      = 1'b1;
        rx_pulse = 1'b0;
        rx_bit   = 1'b1;
        rx_se0   = 1'b0;
        line     = 1'b1;
        ones     = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        pkt_bytes = {8'hA5};
        run_packet(PK_GOOD, 7, 0);
        pkt_bytes = {8'hFF, 8'h00};
        run_packet(PK_GOOD, 7, 0);

        // Seven consecutive decoded ones (sync one + six data ones).
        idle_lead();
        check("rx_active idle", 32'(rx_active), 32'd0);
`ifdef USB_RX_STUFF_ERR_EN
        send_sync(7);
        push(EV_ERROR, 8'h00);
        repeat (6) send_dec(1'b1);
        recover();
`else
        send_sync(7);
        push(EV_VALID, 8'h1F);
        repeat (6) send_dec(1'b1);
        repeat (3) send_dec(1'b0);
        push(EV_VALID, 8'h00);
        repeat (8) send_dec(1'b0);
        send_eop(2);
`endif

        pkt_bytes = {8'h3C};
        run_packet(PK_PARTIAL, 7, 3);
        pkt_bytes = {8'h81};
        run_packet(PK_GOOD, 7, 0);
        pkt_bytes.delete();
        run_packet(PK_SHORT_SYNC, 3, 0);
        pkt_bytes = {8'h42};
        run_packet(PK_LONG_SE0, 7, 0);

        // Reset in the middle of a byte, coinciding with a strobe.
        idle_lead();
        send_sync(6);
        for (int i = 0; i < 4; i++) send_data_bit(1'($urandom));
        rst      = 1'b1;
        rx_pulse = 1'b1;
        rx_bit   = 1'b0;
        rx_se0   = 1'b0;
        @(posedge clk);
        #1;
        rx_pulse = 1'b0;
        exp_q.delete();
        check_all_zero("mid-packet reset");
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        line = 1'b1;
        pkt_bytes = {8'hC3, 8'h7E};
        run_packet(PK_GOOD, 7, 0);

        for (int n = 0; n < 60; n++) begin
            kind = pk_t'($urandom_range(0, 4));
            nb   = $urandom_range(0, 4);
            pkt_bytes.delete();
            for (int i = 0; i < nb; i++) pkt_bytes.push_back(8'($urandom));
            if (kind == PK_SHORT_SYNC)
                run_packet(kind, $urandom_range(1, SYNC_MIN_ZEROS - 1), 0);
            else
                run_packet(kind, $urandom_range(SYNC_MIN_ZEROS, 8), $urandom_range(1, 7));
        end

        repeat (20) @(posedge clk);
        #1;
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
